// File: rtl/spi_bridge_pkg.sv
// Shared types and default constants for the SPI-slave to word-bus bridge.
package spi_bridge_pkg;

    localparam int DEFAULT_WORD_SIZE   = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_STRETCH     = 4;

    // SPI mode 0: sck idles low, data sampled on the rising edge.
    localparam logic [1:0] SPI_MODE = 2'd0;
    localparam logic       SPI_CPOL = SPI_MODE[1];
    localparam logic       SPI_CPHA = SPI_MODE[0];

    typedef enum logic {
        IDLE,
        SHIFT
    } bridge_state_t;

endpackage

// File: rtl/spi_word_bridge_if.sv
// Bundle of SPI pins plus the controller-side word buses.
// The bridge connects through 'slave'; the host/controller side uses 'master'.
interface spi_word_bridge_if
    import spi_bridge_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
    logic                 spi_sck;
    logic                 spi_cs_n;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 rx_valid;
    logic [WORD_SIZE-1:0] rx_data;
    logic                 tx_valid;
    logic [WORD_SIZE-1:0] tx_data;
    logic                 tx_ready;
    logic [7:0]           abort_cnt;

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, tx_valid, tx_data,
        output spi_miso, rx_valid, rx_data, tx_ready, abort_cnt
    );

    modport master (
        output spi_sck, spi_cs_n, spi_mosi, tx_valid, tx_data,
        input  spi_miso, rx_valid, rx_data, tx_ready, abort_cnt
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin plus registered edge detection.
// Edges appear SYNC_STAGES+1 cycles after the pin changes; level_o is aligned with them.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, previous-value flop and registered edge flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: everything resets low, so a pin already low when reset drops
            // produces no falling edge; chip select must be seen high again first.
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_last;
            rise_q <= sync_last & ~prev_q;
            fall_q <= ~sync_last & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/spi_word_bridge.sv
// SPI mode-0 slave to word-bus bridge, single clock domain with oversampled pins.
// Optional feature: define SPI_BRIDGE_ABORT_CNT_EN to build the saturating
// aborted-word counter; otherwise abort_cnt reads as zero.
module spi_word_bridge
    import spi_bridge_pkg::*;
#(
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int STRETCH     = DEFAULT_STRETCH
) (
    input  logic             clk,
    input  logic             reset,
    spi_word_bridge_if.slave bus
);
    localparam int CNT_W = $clog2(WORD_SIZE);
    localparam int STR_W = $clog2(STRETCH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic txv_level, tx_rise, txv_fall;
    logic sync_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .pin_i(bus.spi_sck),
        .level_o(sck_level), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .pin_i(bus.spi_cs_n),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .pin_i(bus.spi_mosi),
        .level_o(mosi_level), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    // tx_valid is already in the clk domain; one stage gives the registered compare.
    spi_pin_sync #(.SYNC_STAGES(1)) u_edge_txv (
        .clk(clk), .reset(reset), .pin_i(bus.tx_valid),
        .level_o(txv_level), .rise_o(tx_rise), .fall_o(txv_fall)
    );

    // Synchroniser outputs this bridge does not consume.
    assign sync_unused = &{1'b0, sck_level, cs_level, mosi_rise, mosi_fall, txv_level, txv_fall};

    bridge_state_t        state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_SIZE-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_SIZE-1:0] rx_data_q, rx_data_d;
    logic [STR_W-1:0]     rx_str_q, rx_str_d;
    logic [WORD_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_SIZE-1:0] tx_hold_q, tx_hold_d;
    logic                 tx_hold_full_q, tx_hold_full_d;
    logic [STR_W-1:0]     tx_str_q, tx_str_d;
    logic                 load_tx;

    // Next-state logic: frame FSM, shift registers, hold register and stretch counters.
    always_comb begin
        // NOTE: every _d gets a default first, so no branch can leave one
        // unassigned and infer a latch; combinational blocks use '=' only.
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        tx_shift_d     = tx_shift_q;
        tx_hold_d      = tx_hold_q;
        tx_hold_full_d = tx_hold_full_q;
        rx_str_d       = (rx_str_q != '0) ? rx_str_q - STR_W'(1) : '0;
        tx_str_d       = (tx_str_q != '0) ? tx_str_q - STR_W'(1) : '0;
        load_tx        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    load_tx   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    // A partial word is simply dropped; rx_data keeps the last full word.
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[WORD_SIZE-2:0], mosi_level};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d = rx_shift_d;
                        bit_cnt_d = '0;
                        rx_str_d  = STR_LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q == '0) begin
                        load_tx = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Hold-to-shift load uses the old hold value; a same-cycle capture below
        // then refills the hold register.
        if (load_tx) begin
            tx_shift_d     = tx_hold_full_q ? tx_hold_q : '0;
            tx_hold_full_d = 1'b0;
            tx_str_d       = STR_LOAD;
        end

        if (tx_rise) begin
            tx_hold_d      = bus.tx_data;
            tx_hold_full_d = 1'b1;
        end
    end

    // Register update with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use '<=' only, so every flop samples pre-edge values.
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_str_q       <= '0;
            tx_shift_q     <= '0;
            tx_hold_q      <= '0;
            tx_hold_full_q <= 1'b0;
            tx_str_q       <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_str_q       <= rx_str_d;
            tx_shift_q     <= tx_shift_d;
            tx_hold_q      <= tx_hold_d;
            tx_hold_full_q <= tx_hold_full_d;
            tx_str_q       <= tx_str_d;
        end
    end

`ifdef SPI_BRIDGE_ABORT_CNT_EN
    logic       abort_inc;
    logic [7:0] abort_cnt_q, abort_cnt_d;

    assign abort_inc = (state_q == SHIFT) && cs_rise && (bit_cnt_q != '0);

    // Saturating count of words cut short by chip select rising.
    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (abort_inc && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end
    end

    // Abort counter register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            abort_cnt_q <= 8'h00;
        end else begin
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign bus.abort_cnt = abort_cnt_q;
`else
    assign bus.abort_cnt = 8'h00;
`endif

    assign bus.rx_valid = (rx_str_q != '0);
    assign bus.rx_data  = rx_data_q;
    assign bus.tx_ready = (tx_str_q != '0);
    assign bus.spi_miso = (state_q == SHIFT) ? tx_shift_q[WORD_SIZE-1] : 1'b0;
endmodule

// File: tb/tb_spi_word_bridge.sv
// Self-checking bench for spi_word_bridge: acts as SPI host (sck = clk/8) and
// word-bus controller; received words are scoreboarded against what was sent.
`timescale 1ns/1ps
module tb_spi_word_bridge;
    import spi_bridge_pkg::*;

    localparam int W       = 16;
    localparam int SYNC    = 2;
    localparam int STRETCH = 4;
    localparam int HALF    = 4;   // clk cycles per sck half period

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_word_bridge_if #(.WORD_SIZE(W)) bif ();

    spi_word_bridge #(
        .WORD_SIZE(W), .SYNC_STAGES(SYNC), .STRETCH(STRETCH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif.slave)
    );

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         last_rise_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int         len_q[$];
    int         lat_q[$];
    int         rx_rises  = 0;
    int         txr_rises = 0;
    logic       prev_rxv  = 1'b0;
    logic       prev_txr  = 1'b0;
    int         run_len   = 0;

    // Output monitor sampled on the falling clock edge.
    always @(negedge clk) begin
        if (bif.rx_valid === 1'b1 && prev_rxv !== 1'b1) begin
            obs_q.push_back(bif.rx_data);
            lat_q.push_back(cyc - last_rise_cyc);
            rx_rises = rx_rises + 1;
            run_len  = 1;
        end else if (bif.rx_valid === 1'b1) begin
            run_len = run_len + 1;
        end else if (prev_rxv === 1'b1) begin
            len_q.push_back(run_len);
        end
        if (bif.tx_ready === 1'b1 && prev_txr !== 1'b1) txr_rises = txr_rises + 1;
        prev_rxv = bif.rx_valid;
        prev_txr = bif.tx_ready;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_begin();
        bif.spi_cs_n = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        bif.spi_cs_n = 1'b1;
        tick(4 * HALF);
    endtask

    // Clock out nbits of w, MSB first; MISO is sampled just before each rise.
    task automatic send_bits(input logic [W-1:0] w, input int nbits, output logic [W-1:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < nbits; i++) begin
            bif.spi_mosi = w[W-1-i];
            tick(HALF);
            miso_w[W-1-i] = bif.spi_miso;
            bif.spi_sck   = 1'b1;
            last_rise_cyc = cyc;
            tick(HALF);
            bif.spi_sck = SPI_CPOL;
        end
        if (nbits == W) exp_q.push_back(w);
    endtask

    // Wait (bounded) for an observed word and pop it with its expectation.
    task automatic get_rx(output logic [W-1:0] e, output logic [W-1:0] o, output bit got);
        int n = 0;
        while (obs_q.size() == 0 && n < 200) begin
            tick(1);
            n++;
        end
        got = (obs_q.size() != 0) && (exp_q.size() != 0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        o = (obs_q.size() != 0) ? obs_q.pop_front() : 'x;
    endtask

    task automatic flush_queues();
        obs_q.delete();
        exp_q.delete();
        len_q.delete();
        lat_q.delete();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bif.spi_sck   = SPI_CPOL;
        bif.spi_cs_n  = 1'b1;
        bif.spi_mosi  = 1'b0;
        bif.tx_valid  = 1'b0;
        bif.tx_data   = '0;
        tick(3);
        reset = 1'b0;
        tick(2);
        checks++; if (bif.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", bif.rx_valid); end
        checks++; if (bif.rx_data !== 16'h0000) begin failures++; $display("FAIL reset_rx_data got=%h exp=0000", bif.rx_data); end
        checks++; if (bif.tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready got=%b exp=0", bif.tx_ready); end
        checks++; if (bif.spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", bif.spi_miso); end
        checks++; if (bif.abort_cnt !== 8'h00) begin failures++; $display("FAIL reset_abort_cnt got=%h exp=00", bif.abort_cnt); end
    endtask

    task automatic test_single_word();
        logic [W-1:0] m, e, o;
        bit got;
        int n = 0;
        flush_queues();
        cs_begin();
        send_bits(16'h4000, W, m);
        cs_end();
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL single_rx_data got=%h exp=%h", o, e); end
        while (len_q.size() == 0 && n < 100) begin tick(1); n++; end
        checks++;
        if (len_q.size() == 0 || len_q[0] !== STRETCH) begin
            failures++; $display("FAIL single_rx_valid_len got=%0d exp=%0d", (len_q.size() != 0) ? len_q[0] : -1, STRETCH);
        end
        checks++;
        if (lat_q.size() == 0 || lat_q[0] !== SYNC + 2) begin
            failures++; $display("FAIL single_rx_latency got=%0d exp=%0d", (lat_q.size() != 0) ? lat_q[0] : -1, SYNC + 2);
        end
        checks++; if (bif.abort_cnt !== 8'h00) begin failures++; $display("FAIL single_abort_cnt got=%h exp=00", bif.abort_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] m, e, o;
        bit got;
        int r0;
        flush_queues();
        r0 = rx_rises;
        cs_begin();
        send_bits(16'h5001, W, m);
        send_bits(16'hA5A5, W, m);
        cs_end();
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL b2b_word0 got=%h exp=%h", o, e); end
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL b2b_word1 got=%h exp=%h", o, e); end
        checks++; if (rx_rises - r0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", rx_rises - r0); end
    endtask

    task automatic test_tx_path();
        logic [W-1:0] m1, m2, e, o;
        bit got;
        int t0;
        flush_queues();
        bif.tx_data  = 16'h1234;
        bif.tx_valid = 1'b1;
        tick(3);
        bif.tx_valid = 1'b0;
        tick(3);
        t0 = txr_rises;
        cs_begin();
        checks++; if (txr_rises - t0 !== 1) begin failures++; $display("FAIL tx_ready_at_cs_fall got=%0d exp=1", txr_rises - t0); end
        send_bits(16'h0001, W, m1);
        send_bits(16'h0002, W, m2);
        cs_end();
        checks++; if (m1 !== 16'h1234) begin failures++; $display("FAIL tx_miso_word0 got=%h exp=1234", m1); end
        checks++; if (m2 !== 16'h0000) begin failures++; $display("FAIL tx_miso_empty got=%h exp=0000", m2); end
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL tx_rx_word0 got=%h exp=%h", o, e); end
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL tx_rx_word1 got=%h exp=%h", o, e); end
    endtask

    task automatic test_abort();
        logic [W-1:0] m;
        logic [7:0]   exp_abort;
        int r0;
        flush_queues();
`ifdef SPI_BRIDGE_ABORT_CNT_EN
        exp_abort = 8'h01;
`else
        exp_abort = 8'h00;
`endif
        r0 = rx_rises;
        cs_begin();
        send_bits(16'hFFFF, 7, m);
        cs_end();
        checks++; if (rx_rises !== r0) begin failures++; $display("FAIL abort_no_rx_valid got=%0d exp=%0d", rx_rises, r0); end
        checks++; if (bif.rx_data !== 16'h0002) begin failures++; $display("FAIL abort_rx_data_held got=%h exp=0002", bif.rx_data); end
        checks++; if (bif.abort_cnt !== exp_abort) begin failures++; $display("FAIL abort_cnt got=%h exp=%h", bif.abort_cnt, exp_abort); end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] m1, m2, e, o;
        bit got;
        flush_queues();
        bif.tx_data  = 16'h1111;
        bif.tx_valid = 1'b1;
        tick(3);
        bif.tx_valid = 1'b0;
        tick(3);
        // tx_valid rises one cycle after cs_n falls: both are acted on in the same cycle.
        bif.spi_cs_n = 1'b0;
        tick(1);
        bif.tx_data  = 16'hBEEF;
        bif.tx_valid = 1'b1;
        tick(3);
        bif.tx_valid = 1'b0;
        tick(4);
        send_bits(16'h0003, W, m1);
        send_bits(16'h0004, W, m2);
        cs_end();
        checks++; if (m1 !== 16'h1111) begin failures++; $display("FAIL simul_current_word got=%h exp=1111", m1); end
        checks++; if (m2 !== 16'hBEEF) begin failures++; $display("FAIL simul_next_word got=%h exp=beef", m2); end
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL simul_rx_word0 got=%h exp=%h", o, e); end
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL simul_rx_word1 got=%h exp=%h", o, e); end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] m, e, o;
        bit got;
        int r0;
        flush_queues();
        cs_begin();
        send_bits(16'h1234, 5, m);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++; if (bif.rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid got=%b exp=0", bif.rx_valid); end
        checks++; if (bif.rx_data !== 16'h0000) begin failures++; $display("FAIL midrst_rx_data got=%h exp=0000", bif.rx_data); end
        checks++; if (bif.tx_ready !== 1'b0) begin failures++; $display("FAIL midrst_tx_ready got=%b exp=0", bif.tx_ready); end
        checks++; if (bif.spi_miso !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b exp=0", bif.spi_miso); end
        checks++; if (bif.abort_cnt !== 8'h00) begin failures++; $display("FAIL midrst_abort_cnt got=%h exp=00", bif.abort_cnt); end
        r0 = rx_rises;
        send_bits(16'h1234 << 5, W - 5, m);
        cs_end();
        checks++; if (rx_rises !== r0) begin failures++; $display("FAIL midrst_ignored_frame got=%0d exp=%0d", rx_rises, r0); end
        checks++; if (bif.rx_data !== 16'h0000) begin failures++; $display("FAIL midrst_rx_data_after got=%h exp=0000", bif.rx_data); end
        // A fresh frame after reset is received normally.
        cs_begin();
        send_bits(16'h0F0F, W, m);
        cs_end();
        get_rx(e, o, got);
        checks++; if (!got || o !== e) begin failures++; $display("FAIL midrst_recovery got=%h exp=%h", o, e); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_tx_path();
        test_abort();
        test_simultaneous();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout reached checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
